pipe_stage_hs: RTL and testbench

Parametrised pipeline-stage register that replaces the fixed inst/pc/pc4 inter-stage registers with one generic payload register. It carries a valid/ready handshake, an optional 2-entry skid buffer so upstream ready is registered, and a synchronous flush that inserts a bubble. It also keeps a saturating backpressure counter. It is instantiated between every pair of CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_skid_buf.sv | 101 ++++++++++
 rtl/pipe_stage_hs.sv | 118 +++++++++++
 tb/tb_pipe_stage_hs.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers.
//   - IF/ID payload layout (inst, pc, pc4 packed into 3*XLEN bits)
//   - NOP instruction and an IF/ID bubble built from it
//   - encoding of the skid-buffer state as {main_valid, skid_valid}
//   - helper that turns the two valid bits into a beat count
package pipe_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INST_LSB = 64;
    localparam int unsigned PC_LSB   = 32;
    localparam int unsigned PC4_LSB  = 0;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0]   NOP_INST        = 32'h0000_0013;
    localparam logic [3*XLEN-1:0] IFID_NOP_BUBBLE = {NOP_INST, {XLEN{1'b0}}, {XLEN{1'b0}}};

    // State of the two-entry buffer, written as {main_valid, skid_valid}
    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_FULL1   = 2'b10;
    localparam logic [1:0] ST_FULL2   = 2'b11;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;

    function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
        return {1'b0, main_valid} + {1'b0, skid_valid};
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered upstream ready.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   flush_i             synchronous flush, drops both held beats
//   in_valid_i/in_data_i  upstream beat;  in_ready_o = ~skid_valid (registered)
//   out_ready_i         downstream accept
//   main_valid_o/main_data_o  head beat;  skid_valid_o  second beat held
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = 96,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              out_ready_i,
    output logic              main_valid_o,
    output logic              skid_valid_o,
    output logic [DATA_W-1:0] main_data_o
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_fire, out_fire;

    // Ready depends only on registered state, so out_ready_i never reaches in_ready_o.
    assign in_ready_o = ~skid_valid_q;
    assign in_fire    = in_valid_i & ~skid_valid_q;
    assign out_fire   = main_valid_q & out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = BUBBLE;
            skid_data_d  = BUBBLE;
        end else begin
            case ({main_valid_q, skid_valid_q})
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data_i;
                    end
                end
                ST_FULL1: begin
                    if (out_fire && in_fire) begin
                        main_data_d = in_data_i;
                    end else if (out_fire) begin
                        main_valid_d = 1'b0;
                    end else if (in_fire) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data_i;
                    end
                end
                ST_FULL2: begin
                    // Head leaves; the skid beat moves up so arrival order is kept.
                    if (out_fire) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= BUBBLE;
            skid_data_q  <= BUBBLE;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    a_no_illegal_state: assert property (@(posedge clk) disable iff (!rst_n)
        {main_valid_q, skid_valid_q} != ST_ILLEGAL);

    assign main_valid_o = main_valid_q;
    assign skid_valid_o = skid_valid_q;
    assign main_data_o  = main_data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic pipeline-stage register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   flush_i                     drop all held beats, load BUBBLE
//   in_valid_i/in_ready_o/in_data_i     upstream handshake
//   out_valid_o/out_ready_i/out_data_o  downstream handshake
//   occupancy_o                 beats held (0..2)
//   stall_cnt_o                 cycles with out_valid_o & ~out_ready_i, saturating
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = 96,
    parameter bit                SKID   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic              in_ready;

    generate
        if (SKID) begin : g_skid
            pipe_skid_buf #(
                .DATA_W (DATA_W),
                .BUBBLE (BUBBLE)
            ) u_skid (
                .clk          (clk),
                .rst_n        (rst_n),
                .flush_i      (flush_i),
                .in_valid_i   (in_valid_i),
                .in_data_i    (in_data_i),
                .in_ready_o   (in_ready),
                .out_ready_i  (out_ready_i),
                .main_valid_o (main_valid),
                .skid_valid_o (skid_valid),
                .main_data_o  (main_data)
            );
        end else begin : g_single
            logic              main_valid_q, main_valid_d;
            logic [DATA_W-1:0] main_data_q,  main_data_d;

            // Combinational ready: a full register can take a beat when the head leaves.
            assign in_ready = ~main_valid_q | out_ready_i;

            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                if (flush_i) begin
                    main_valid_d = 1'b0;
                    main_data_d  = BUBBLE;
                end else if (in_valid_i && in_ready) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data_i;
                end else if (main_valid_q && out_ready_i) begin
                    main_valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid_q <= 1'b0;
                    main_data_q  <= BUBBLE;
                end else begin
                    main_valid_q <= main_valid_d;
                    main_data_q  <= main_data_d;
                end
            end

            assign main_valid = main_valid_q;
            assign main_data  = main_data_q;
            assign skid_valid = 1'b0;
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Flush does not clear the counter; only reset does.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !out_ready_i) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;
    assign occupancy_o = occ_count(main_valid, skid_valid);
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

    localparam int DW = 96;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut1: SKID=1, CNT_W=4
    logic          f1 = 0, iv1 = 0, or1 = 0;
    logic          ir1, ov1;
    logic [DW-1:0] id1 = '0, od1;
    logic [1:0]    occ1;
    logic [3:0]    sc1;
    // dut0: SKID=0, CNT_W=16
    logic          f0 = 0, iv0 = 0, or0 = 0;
    logic          ir0, ov0;
    logic [DW-1:0] id0 = '0, od0;
    logic [1:0]    occ0;
    logic [15:0]   sc0;

    pipe_stage_hs #(.DATA_W(DW), .SKID(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(f1),
        .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(id1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1),
        .occupancy_o(occ1), .stall_cnt_o(sc1));

    pipe_stage_hs #(.DATA_W(DW), .SKID(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(f0),
        .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(id0),
        .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0),
        .occupancy_o(occ0), .stall_cnt_o(sc0));

    int passed = 0;
    int total  = 0;

    // Reference model: each stage is a FIFO of held beats.
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    int unsigned   c1 = 0, c0 = 0;

    task automatic model_clear();
        q1.delete(); q0.delete(); c1 = 0; c0 = 0;
    endtask

    task automatic model_edge();
        bit inf1, outf1, inf0, outf0;
        inf1  = iv1 && (q1.size() < 2);
        outf1 = (q1.size() > 0) && or1;
        if (q1.size() > 0 && !or1 && c1 < 15) c1++;
        if (f1) q1.delete();
        else begin
            if (outf1) void'(q1.pop_front());
            if (inf1) q1.push_back(id1);
        end
        inf0  = iv0 && (q0.size() == 0 || or0);
        outf0 = (q0.size() > 0) && or0;
        if (q0.size() > 0 && !or0 && c0 < 65535) c0++;
        if (f0) q0.delete();
        else begin
            if (outf0) void'(q0.pop_front());
            if (inf0) q0.push_back(id0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        f1 = 0; iv1 = 0; or1 = 0; id1 = '0;
        f0 = 0; iv0 = 0; or0 = 0; id0 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ov1 !== 1'b0) $display("FAIL reset_ov1: got %b want 0", ov1); else passed++;
        total++; if (od1 !== '0) $display("FAIL reset_od1: got %h want 0", od1); else passed++;
        total++; if (occ1 !== 2'd0) $display("FAIL reset_occ1: got %0d want 0", occ1); else passed++;
        total++; if (sc1 !== 4'd0) $display("FAIL reset_sc1: got %0d want 0", sc1); else passed++;
        total++; if (ir1 !== 1'b1) $display("FAIL reset_ir1: got %b want 1", ir1); else passed++;
        total++; if (ov0 !== 1'b0) $display("FAIL reset_ov0: got %b want 0", ov0); else passed++;
        total++; if (ir0 !== 1'b1) $display("FAIL reset_ir0: got %b want 1", ir0); else passed++;
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp;
        do_reset();
        or1 = 1;
        for (int k = 0; k < 3; k++) begin
            iv1 = 1; id1 = DW'(8'h10 + k);
            cycle();
            exp = DW'(8'h10 + k);
            total++; if (ov1 !== 1'b1 || od1 !== exp)
                $display("FAIL stream_data%0d: got v=%b %h want v=1 %h", k, ov1, od1, exp); else passed++;
            total++; if (occ1 !== 2'd1)
                $display("FAIL stream_occ%0d: got %0d want 1", k, occ1); else passed++;
        end
        iv1 = 0;
        cycle();
        total++; if (occ1 !== 2'd0 || ov1 !== 1'b0)
            $display("FAIL stream_drain: got occ=%0d v=%b want 0 0", occ1, ov1); else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        or1 = 0;
        iv1 = 1; id1 = DW'(8'hA0);
        cycle();
        total++; if (occ1 !== 2'd1 || ir1 !== 1'b1)
            $display("FAIL bp_first: got occ=%0d rdy=%b want 1 1", occ1, ir1); else passed++;
        id1 = DW'(8'hA1);
        cycle();
        total++; if (occ1 !== 2'd2 || ir1 !== 1'b0)
            $display("FAIL bp_full: got occ=%0d rdy=%b want 2 0", occ1, ir1); else passed++;
        id1 = DW'(8'hA2);
        cycle();
        total++; if (occ1 !== 2'd2 || od1 !== DW'(8'hA0))
            $display("FAIL bp_hold: got occ=%0d d=%h want 2 a0", occ1, od1); else passed++;
        total++; if (sc1 !== 4'd2)
            $display("FAIL bp_stallcnt: got %0d want 2", sc1); else passed++;
        or1 = 1;
        cycle();
        total++; if (od1 !== DW'(8'hA1) || occ1 !== 2'd1)
            $display("FAIL bp_deliver_a1: got d=%h occ=%0d want a1 1", od1, occ1); else passed++;
        cycle();
        total++; if (od1 !== DW'(8'hA2) || occ1 !== 2'd1)
            $display("FAIL bp_deliver_a2: got d=%h occ=%0d want a2 1", od1, occ1); else passed++;
        iv1 = 0;
        cycle();
        total++; if (occ1 !== 2'd0 || sc1 !== 4'd2)
            $display("FAIL bp_end: got occ=%0d cnt=%0d want 0 2", occ1, sc1); else passed++;
    endtask

    task automatic test_flush();
        or1 = 0;
        iv1 = 1; id1 = DW'(8'hB0);
        cycle();
        id1 = DW'(8'hB1);
        cycle();
        total++; if (occ1 !== 2'd2)
            $display("FAIL flush_prefill: got occ=%0d want 2", occ1); else passed++;
        f1 = 1; id1 = DW'(8'hFF);
        cycle();
        f1 = 0; iv1 = 0;
        total++; if (occ1 !== 2'd0 || ov1 !== 1'b0 || od1 !== '0)
            $display("FAIL flush_clear: got occ=%0d v=%b d=%h want 0 0 0", occ1, ov1, od1); else passed++;
        total++; if (32'(sc1) !== c1 || sc1 === 4'd0)
            $display("FAIL flush_keeps_cnt: got %0d want %0d", sc1, c1); else passed++;
        or1 = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++; if (ov1 !== 1'b0)
                $display("FAIL flush_no_ff%0d: got v=%b d=%h want v=0", k, ov1, od1); else passed++;
        end
    endtask

    task automatic test_skid0();
        do_reset();
        or0 = 0; iv0 = 1; id0 = DW'(8'h55);
        cycle();
        iv0 = 0;
        total++; if (ov0 !== 1'b1 || occ0 !== 2'd1 || od0 !== DW'(8'h55))
            $display("FAIL s0_load: got v=%b occ=%0d d=%h want 1 1 55", ov0, occ0, od0); else passed++;
        total++; if (ir0 !== 1'b0) $display("FAIL s0_rdy_lo: got %b want 0", ir0); else passed++;
        or0 = 1; #1;
        total++; if (ir0 !== 1'b1) $display("FAIL s0_rdy_follow: got %b want 1", ir0); else passed++;
        or0 = 0; #1;
        total++; if (ir0 !== 1'b0) $display("FAIL s0_rdy_drop: got %b want 0", ir0); else passed++;
        or0 = 1; iv0 = 1; id0 = DW'(8'h56);
        cycle();
        total++; if (occ0 !== 2'd1 || od0 !== DW'(8'h56))
            $display("FAIL s0_bothfire: got occ=%0d d=%h want 1 56", occ0, od0); else passed++;
        iv0 = 0;
        cycle();
        total++; if (occ0 !== 2'd0) $display("FAIL s0_drain: got %0d want 0", occ0); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        or1 = 0; iv1 = 1; id1 = DW'(8'h77);
        cycle();
        iv1 = 0;
        repeat (20) cycle();
        total++; if (sc1 !== 4'd15) $display("FAIL sat_reach: got %0d want 15", sc1); else passed++;
        repeat (3) cycle();
        total++; if (sc1 !== 4'd15) $display("FAIL sat_hold: got %0d want 15", sc1); else passed++;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        model_clear();
        total++; if (sc1 !== 4'd0 || ov1 !== 1'b0 || occ1 !== 2'd0 || od1 !== '0)
            $display("FAIL async_rst: got cnt=%0d v=%b occ=%0d d=%h want 0 0 0 0",
                     sc1, ov1, occ1, od1); else passed++;
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_random();
        logic [7:0] exp1, got1;
        logic [19:0] exp0, got0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            iv1 = 1'($urandom_range(0, 1)); or1 = ($urandom_range(0, 9) < 6);
            f1  = ($urandom_range(0, 29) == 0); id1 = {$urandom, $urandom, $urandom};
            iv0 = 1'($urandom_range(0, 1)); or0 = ($urandom_range(0, 9) < 6);
            f0  = ($urandom_range(0, 29) == 0); id0 = {$urandom, $urandom, $urandom};
            #1;
            exp1 = {q1.size() < 2, q1.size() > 0, 2'(q1.size()), 4'(c1)};
            got1 = {ir1, ov1, occ1, sc1};
            total++; if (got1 !== exp1)
                $display("FAIL rnd_ctrl1 @%0d: got %h want %h", n, got1, exp1); else passed++;
            if (q1.size() > 0) begin
                total++; if (od1 !== q1[0])
                    $display("FAIL rnd_data1 @%0d: got %h want %h", n, od1, q1[0]); else passed++;
            end
            exp0 = {(q0.size() == 0) || or0, q0.size() > 0, 2'(q0.size()), 16'(c0)};
            got0 = {ir0, ov0, occ0, sc0};
            total++; if (got0 !== exp0)
                $display("FAIL rnd_ctrl0 @%0d: got %h want %h", n, got0, exp0); else passed++;
            if (q0.size() > 0) begin
                total++; if (od0 !== q0[0])
                    $display("FAIL rnd_data0 @%0d: got %h want %h", n, od0, q0[0]); else passed++;
            end
            cycle();
        end
        f1 = 0; f0 = 0; iv1 = 0; iv0 = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
